// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller for the MIPS data bus.
//   Bus side : sysclk, reset (async, active-low), addr, MemRead, MemWrite,
//              wdata -> rdata (combinational), irq (level).
//   Sender   : TX_DATA/TX_EN out, TX_STATUS in (1 = idle, asynchronous).
//   Receiver : RX_DATA/RX_STATUS in (RX_STATUS asynchronous, rising = new byte).
// Outgoing bytes queue in a TX_DEPTH-entry FIFO and are handed to the sender
// one frame at a time. Received bytes are latched on the synchronized
// RX_STATUS rising edge. Registers: TXD (write-only), RXD (read-only), CON.
module uart_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [31:0] TXD_ADDR = 32'h4000_0018,
  parameter logic [31:0] RXD_ADDR = 32'h4000_001C,
  parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  TX_DATA,
  output logic        TX_EN,
  input  logic        TX_STATUS,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STATUS
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Synchronizers: TX_STATUS idles high, RX_STATUS idles low.
  logic txs_s1_q, txs_s_q;
  logic rxs_s1_q, rxs_s_q, rxs_d_q;

  state_t          state_q, state_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_hold_q, tx_hold_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      fifo_mem [TX_DEPTH];

  logic            tx_done_q, tx_done_d;
  logic            tx_ie_q, tx_ie_d;
  logic            rx_ie_q, rx_ie_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic [7:0]      rx_buf_q, rx_buf_d;

  logic wr_txd, wr_con, rd_rxd;
  logic tx_full, tx_empty, tx_busy;
  logic push, pop, done_set, rx_rise;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign wr_txd   = MemWrite && (addr == TXD_ADDR);
  assign wr_con   = MemWrite && (addr == CON_ADDR);
  assign rd_rxd   = MemRead  && (addr == RXD_ADDR);

  assign tx_full  = (count_q == CW'(TX_DEPTH));
  assign tx_empty = (count_q == '0);
  assign tx_busy  = (state_q != S_IDLE) || !tx_empty;

  // A write to a full FIFO is dropped even if a pop happens in the same cycle.
  assign push     = wr_txd && !tx_full;
  assign pop      = (state_q == S_IDLE) && !tx_empty && txs_s_q;
  assign rx_rise  = rxs_s_q && !rxs_d_q;

  always_comb begin
    state_d  = state_q;
    tx_en_d  = tx_en_q;
    done_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_en_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!txs_s_q) begin
          tx_en_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (txs_s_q) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tx_hold_d = pop  ? fifo_mem[rd_ptr_q] : tx_hold_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flag updates: a set event always overrides a software clear.
  always_comb begin
    tx_done_d  = tx_done_q;
    if (wr_con && wdata[2]) tx_done_d = 1'b0;
    if (done_set)           tx_done_d = 1'b1;

    rx_ovr_d   = rx_ovr_q;
    if (wr_con && wdata[6])     rx_ovr_d = 1'b0;
    if (rx_rise && rx_valid_q)  rx_ovr_d = 1'b1;

    rx_valid_d = rx_valid_q;
    if (rd_rxd)  rx_valid_d = 1'b0;
    if (rx_rise) rx_valid_d = 1'b1;

    rx_buf_d   = rx_rise ? RX_DATA : rx_buf_q;
    tx_ie_d    = wr_con ? wdata[0] : tx_ie_q;
    rx_ie_d    = wr_con ? wdata[1] : rx_ie_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      txs_s1_q   <= 1'b1;
      txs_s_q    <= 1'b1;
      rxs_s1_q   <= 1'b0;
      rxs_s_q    <= 1'b0;
      rxs_d_q    <= 1'b0;
      state_q    <= S_IDLE;
      tx_en_q    <= 1'b0;
      tx_hold_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_done_q  <= 1'b0;
      tx_ie_q    <= 1'b0;
      rx_ie_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_buf_q   <= '0;
    end else begin
      txs_s1_q   <= TX_STATUS;
      txs_s_q    <= txs_s1_q;
      rxs_s1_q   <= RX_STATUS;
      rxs_s_q    <= rxs_s1_q;
      rxs_d_q    <= rxs_s_q;
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      tx_hold_q  <= tx_hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_done_q  <= tx_done_d;
      tx_ie_q    <= tx_ie_d;
      rx_ie_q    <= rx_ie_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_buf_q   <= rx_buf_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers/count.
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (MemRead) begin
      if (addr == RXD_ADDR) begin
        rdata = {24'b0, rx_buf_q};
      end else if (addr == CON_ADDR) begin
        rdata = {25'b0, rx_ovr_q, tx_full, tx_busy, rx_valid_q,
                 tx_done_q, rx_ie_q, tx_ie_q};
      end
    end
  end

  assign irq     = (tx_ie_q && tx_done_q) || (rx_ie_q && rx_valid_q);
  assign TX_DATA = tx_hold_q;
  assign TX_EN   = tx_en_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl with a behavioural sender,
// randomized data bytes, and a reference model of the software-visible state.
module tb_uart_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TXD   = 32'h4000_0018;
  localparam logic [31:0] RXD   = 32'h4000_001C;
  localparam logic [31:0] CON   = 32'h4000_0020;
  localparam int unsigned FRAME = 200;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  TX_DATA;
  logic        TX_EN;
  logic        TX_STATUS;
  logic [7:0]  RX_DATA = '0;
  logic        RX_STATUS = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Behavioural sender state
  logic        snd_idle = 1'b1;
  logic        force_busy = 1'b0;
  logic        chk_stable = 1'b1;
  logic [7:0]  frame_byte = '0;
  int unsigned stable_err = 0;
  logic [7:0]  sent_q [$];
  logic [7:0]  exp_q [$];

  // Reference model of the register state
  logic        m_tie = 0, m_rie = 0, m_done = 0, m_valid = 0, m_ovr = 0;
  logic [7:0]  m_rxbuf = '0;

  assign TX_STATUS = snd_idle & ~force_busy;

  uart_ctrl #(.TX_DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .addr      (addr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .TX_DATA   (TX_DATA),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS)
  );

  always #5 sysclk = ~sysclk;

  // Sender: busy 5 cycles after seeing TX_EN, idle again FRAME cycles later.
  initial begin
    forever begin
      @(posedge sysclk); #1;
      if (TX_EN === 1'b1 && TX_STATUS === 1'b1) begin
        repeat (5) begin @(posedge sysclk); #1; end
        frame_byte = TX_DATA;
        sent_q.push_back(TX_DATA);
        snd_idle = 1'b0;
        repeat (FRAME) begin
          @(posedge sysclk); #1;
          if (chk_stable && TX_DATA !== frame_byte) stable_err++;
        end
        snd_idle = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] con_exp(input logic full, input logic busy);
    return {25'b0, m_ovr, full, busy, m_valid, m_done, m_rie, m_tie};
  endfunction

  function automatic logic exp_irq();
    return (m_tie & m_done) | (m_rie & m_valid);
  endfunction

  // Side-effect-free read, called at a falling edge.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; MemRead = 1'b1; #1; d = rdata; MemRead = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge sysclk); addr = a; wdata = d; MemWrite = 1'b1;
    @(negedge sysclk); MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge sysclk); addr = a; MemRead = 1'b1; #1; d = rdata;
    @(negedge sysclk); MemRead = 1'b0;
  endtask

  task automatic wait_tx_idle(input int unsigned budget, output logic ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge sysclk);
      peek(CON, d);
      if (d[4] == 1'b0 && snd_idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic deliver_rx(input logic [7:0] b);
    @(negedge sysclk); RX_DATA = b; RX_STATUS = 1'b1;
    repeat (4) @(negedge sysclk);
    RX_STATUS = 1'b0;
    repeat (3) @(negedge sysclk);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1; m_rxbuf = b;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    total++; if (TX_EN !== 1'b0) begin bad++; $display("FAIL rst_tx_en: got %b want 0", TX_EN); end
    total++; if (TX_DATA !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", TX_DATA); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    peek(CON, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_con: got %h want 0", d); end
    @(negedge sysclk); reset = 1'b1;
    @(negedge sysclk);
    peek(RXD, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_rxd: got %h want 0", d); end
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL rst_con_post: got %h want %h", d, con_exp(1'b0, 1'b0)); end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    logic [31:0] d;
    logic ok;
    int unsigned n, k;
    sent_q.delete(); stable_err = 0;
    bus_write(TXD, {24'b0, b});
    total++; if (TX_EN !== 1'b0) begin bad++; $display("FAIL txen_early: got %b want 0", TX_EN); end
    @(negedge sysclk);
    total++; if (TX_EN !== 1'b1) begin bad++; $display("FAIL txen_rise: got %b want 1", TX_EN); end
    total++; if (TX_DATA !== b) begin bad++; $display("FAIL tx_data: got %h want %h", TX_DATA, b); end
    n = 0;
    while (TX_STATUS === 1'b1 && n < 20) begin @(negedge sysclk); n++; end
    k = 0;
    while (TX_EN === 1'b1 && k < 10) begin @(negedge sysclk); k++; end
    total++; if (k < 2 || k > 3) begin bad++; $display("FAIL txen_fall_lat: got %0d want 2..3", k); end
    wait_tx_idle(FRAME + 50, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL frame_timeout: got %b want 1", ok); end
    m_done = 1'b1;
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL frame_con: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    total++; if (sent_q.size() != 1 || sent_q[0] !== b) begin bad++; $display("FAIL frame_byte: got n=%0d want %h", sent_q.size(), b); end
    total++; if (stable_err != 0) begin bad++; $display("FAIL frame_stable: got %0d changes want 0", stable_err); end
  endtask

  task automatic check_frames(input string tag);
    total++;
    if (sent_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", tag, sent_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (sent_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL %s_order[%0d]: got %h want %h", tag, i, sent_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic ok;
    force_busy = 1'b1;
    repeat (4) @(negedge sysclk);
    sent_q.delete(); exp_q.delete(); stable_err = 0;
    for (int i = 1; i <= 5; i++) begin
      bus_write(TXD, 32'(i));
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
    end
    peek(CON, d);
    total++; if (d !== con_exp(1'b1, 1'b1)) begin bad++; $display("FAIL ovf_con: got %h want %h", d, con_exp(1'b1, 1'b1)); end
    total++; if (TX_EN !== 1'b0) begin bad++; $display("FAIL ovf_txen: got %b want 0", TX_EN); end
    force_busy = 1'b0;
    wait_tx_idle(DEPTH * (FRAME + 30) + 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_timeout: got %b want 1", ok); end
    check_frames("ovf");
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL ovf_con_end: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    total++; if (stable_err != 0) begin bad++; $display("FAIL ovf_stable: got %0d want 0", stable_err); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int unsigned n;
    n = $urandom_range(2, 4);
    sent_q.delete(); exp_q.delete(); stable_err = 0;
    @(negedge sysclk);
    for (int unsigned i = 0; i < n; i++) begin
      addr = TXD; wdata = 32'($urandom_range(0, 255)); MemWrite = 1'b1;
      exp_q.push_back(wdata[7:0]);
      @(negedge sysclk);
    end
    MemWrite = 1'b0;
    wait_tx_idle(n * (FRAME + 30) + 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout: got %b want 1", ok); end
    check_frames("b2b");
    total++; if (stable_err != 0) begin bad++; $display("FAIL b2b_stable: got %0d want 0", stable_err); end
  endtask

  task automatic test_rx_timing(input logic [7:0] b);
    logic [31:0] d;
    @(negedge sysclk); RX_DATA = b; RX_STATUS = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    peek(CON, d);
    total++; if (d[3] !== 1'b0) begin bad++; $display("FAIL rx_early: got %b want 0", d[3]); end
    @(negedge sysclk);
    peek(CON, d);
    total++; if (d[3] !== 1'b1) begin bad++; $display("FAIL rx_valid_3: got %b want 1", d[3]); end
    @(negedge sysclk); RX_STATUS = 1'b0;
    repeat (3) @(negedge sysclk);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1; m_rxbuf = b;
    bus_read(RXD, d);
    total++; if (d !== {24'b0, m_rxbuf}) begin bad++; $display("FAIL rxd_read: got %h want %h", d, {24'b0, m_rxbuf}); end
    m_valid = 1'b0;
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL rx_clear: got %h want %h", d, con_exp(1'b0, 1'b0)); end
  endtask

  task automatic test_rx_overrun(input logic [7:0] b0, input logic [7:0] b1);
    logic [31:0] d;
    deliver_rx(b0);
    deliver_rx(b1);
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL ovr_con: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    peek(RXD, d);
    total++; if (d !== {24'b0, m_rxbuf}) begin bad++; $display("FAIL ovr_buf: got %h want %h", d, {24'b0, m_rxbuf}); end
    bus_write(CON, 32'h40);
    m_ovr = 1'b0; m_tie = 1'b0; m_rie = 1'b0;
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL ovr_clear: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    bus_read(RXD, d);
    m_valid = 1'b0;
    total++; if (d !== {24'b0, m_rxbuf}) begin bad++; $display("FAIL ovr_rxd: got %h want %h", d, {24'b0, m_rxbuf}); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic ok;
    logic [7:0] b;
    bus_write(CON, 32'h04);
    m_done = 1'b0; m_tie = 1'b0; m_rie = 1'b0;
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_off: got %b want %b", irq, exp_irq()); end
    deliver_rx(8'($urandom_range(0, 255)));
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_masked: got %b want %b", irq, exp_irq()); end
    bus_write(CON, 32'h03);
    m_tie = 1'b1; m_rie = 1'b1;
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_rx: got %b want %b", irq, exp_irq()); end
    bus_read(RXD, d);
    m_valid = 1'b0;
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_rx_clr: got %b want %b", irq, exp_irq()); end
    b = 8'($urandom_range(0, 255));
    sent_q.delete(); exp_q.delete(); exp_q.push_back(b);
    bus_write(TXD, {24'b0, b});
    wait_tx_idle(FRAME + 50, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL irq_tx_timeout: got %b want 1", ok); end
    m_done = 1'b1;
    repeat (20) @(negedge sysclk);
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_tx: got %b want %b", irq, exp_irq()); end
    check_frames("irq");
    bus_write(CON, 32'h07);
    m_done = 1'b0;
    total++; if (irq !== exp_irq()) begin bad++; $display("FAIL irq_tx_clr: got %b want %b", irq, exp_irq()); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic ok;
    int unsigned rises;
    chk_stable = 1'b0;
    @(negedge sysclk);
    for (int i = 0; i < 3; i++) begin
      addr = TXD; wdata = 32'($urandom_range(0, 255)); MemWrite = 1'b1;
      @(negedge sysclk);
    end
    MemWrite = 1'b0;
    total++; if (TX_EN !== 1'b1) begin bad++; $display("FAIL mid_start: got %b want 1", TX_EN); end
    reset = 1'b0;
    m_tie = 0; m_rie = 0; m_done = 0; m_valid = 0; m_ovr = 0; m_rxbuf = '0;
    #1;
    total++; if (TX_EN !== 1'b0) begin bad++; $display("FAIL mid_txen: got %b want 0", TX_EN); end
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL mid_con: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    rises = 0;
    for (int unsigned i = 0; i < FRAME + 100; i++) begin
      @(negedge sysclk);
      if (TX_EN === 1'b1) rises++;
    end
    total++; if (rises != 0) begin bad++; $display("FAIL mid_no_tx: got %0d cycles of TX_EN want 0", rises); end
    wait_tx_idle(50, ok);
    peek(CON, d);
    total++; if (d !== con_exp(1'b0, 1'b0)) begin bad++; $display("FAIL mid_con_end: got %h want %h", d, con_exp(1'b0, 1'b0)); end
    chk_stable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_frame(8'h55);
    test_single_frame(8'($urandom_range(0, 255)));
    test_overflow();
    test_back_to_back();
    test_rx_timing(8'hA3);
    for (int i = 0; i < 3; i++) test_rx_timing(8'($urandom_range(0, 255)));
    test_rx_overrun(8'h11, 8'h22);
    test_rx_overrun(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_irq();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller between the MIPS CPU data bus and the UART sender/receiver pair. It buffers outgoing bytes in a small FIFO and sequences the sender one frame at a time through the TX_EN/TX_STATUS handshake. It captures each received byte on the receiver's RX_STATUS rising edge and exposes status and interrupt bits to software. The bus side runs on sysclk; TX_STATUS and RX_STATUS originate in baud-derived clock domains and are synchronized internally.

## Interface
- TX_DEPTH, 4: TX FIFO depth in bytes (power of two, ≥2).
- TXD_ADDR, 32'h40000018: write-only transmit data register.
- RXD_ADDR, 32'h4000001C: read-only receive data register.
- CON_ADDR, 32'h40000020: control/status register.

Ports:
- sysclk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- addr  in  32  bus address, full-word compare.
- MemRead  in  1  read strobe.
- MemWrite  in  1  write strobe, sampled at the rising edge.
- wdata  in  32  write data.
- rdata  out  32  combinational read data; 0 when MemRead=0 or addr is unmapped.
- irq  out  1  level interrupt to CPU.
- TX_DATA  out  8  byte presented to sender; held stable for the whole frame.
- TX_EN  out  1  transmit request to sender.
- TX_STATUS  in  1  sender idle (1) / busy (0); asynchronous.
- RX_DATA  in  8  receiver data; valid once RX_STATUS is high.
- RX_STATUS  in  1  receiver byte-complete flag; asynchronous.

## Operation
- Synchronizers: TX_STATUS and RX_STATUS each pass through 2 flops (txs_s, rxs_s), reset to 1 and 0 respectively. An rxs_s rising edge is detected with a third flop.
- TX FIFO: circular buffer with pointers and a count of width $clog2(TX_DEPTH)+1. A write to TXD_ADDR pushes wdata[7:0] if not full; when full the write is dropped with no other effect. Push and pop in the same cycle are both performed and the count is unchanged.
- TX FSM states: IDLE, START, WAIT.
  - IDLE: if FIFO non-empty and txs_s=1, pop the head into tx_hold, set TX_EN=1, and go to START.
  - START: hold TX_EN=1 until txs_s=0, then drive TX_EN=0 and go to WAIT.
  - WAIT: when txs_s=1, set tx_done=1 and go to IDLE.
- TX_DATA=tx_hold at all times. tx_hold changes only on a pop.
- RX: on an rxs_s rising edge, load RX_DATA into rx_buf and set rx_valid=1. If rx_valid was already 1, also set rx_ovr=1.
- A read of RXD_ADDR returns {24'b0, rx_buf} and clears rx_valid at the next edge. If a capture occurs in the same cycle, the capture wins: rx_valid stays 1 and rx_buf takes the new byte.
- CON read: {25'b0, rx_ovr, tx_full, tx_busy, rx_valid, tx_done, rx_ie, tx_ie}.
  - tx_busy = (state≠IDLE) | (count≠0).
  - tx_full = (count==TX_DEPTH).
- CON write:
  - bits[1:0] load tx_ie and rx_ie.
  - Writing 1 to bit 2 clears tx_done; writing 1 to bit 6 clears rx_ovr.
  - Other bits are ignored.
  - If a set event and a clear coincide, the set wins.
- irq = (tx_ie & tx_done) | (rx_ie & rx_valid).

## Timing
- Reset values:
  - TX_EN=0, TX_DATA=0, irq=0.
  - state=IDLE, count=0, pointers=0.
  - rx_buf=0, all flags 0, tx_ie=rx_ie=0.
- TXD write at edge N makes count=1 after N. When txs_s=1, TX_EN rises after edge N+1.
- TX_EN falls 2–3 sysclk edges after TX_STATUS actually falls (synchronizer latency).
- rx_valid sets 3 edges after RX_STATUS rises: 2 synchronizer flops plus the edge detect.
- Back-to-back frames: the next pop happens one edge after WAIT→IDLE, provided txs_s is still 1.
- Reset asserted mid-frame: TX_EN drops immediately and the FIFO contents are discarded. The sender may finish its current frame independently. After reset release, the FSM waits in IDLE for txs_s=1 before starting any new frame.
- rdata is combinational from addr/MemRead and current register state. A flag change is visible in the read issued in the cycle after it.

## Test plan
- Write 8'h55 to TXD with a behavioural sender (TX_STATUS drops 5 cycles after TX_EN and returns 200 cycles later) → TX_EN high after the second edge, TX_DATA=8'h55 for the whole frame. Then tx_done=1 and CON read=32'h04.
- Write 5 bytes 8'h01–8'h05 with TX_DEPTH=4 while the sender is held busy → 5th write dropped, CON bit5=1. After release, the frames carry 01, 02, 03, 04 in order, then tx_busy=0.
- Drive RX_DATA=8'hA3 and pulse RX_STATUS high → rx_valid=1 within 3 edges. RXD read returns 32'hA3, then rx_valid=0.
- Deliver two bytes 8'h11, 8'h22 without reading RXD → rx_buf=8'h22, rx_ovr=1. Writing 32'h40 to CON clears rx_ovr.
- Write CON=32'h3 with a pending rx byte → irq=1. Reading RXD makes irq fall; a completed TX frame raises it again until CON is written with bit2=1.
- Assert reset while in START with 2 bytes queued → TX_EN=0 and count=0 immediately. After release, no TX_EN occurs without new writes.
